jux_axi4_rd_slave: RTL
======================

// Module: jux_axi4_rd_slave
// PURPOSE
//  AXI4 read-channel responder (slave end of AR/R). Accepts one burst at a time on AR, reads
//  beats from a 1-cycle-latency synchronous word memory port, returns them on R with correct
//  rid/rresp/rlast. Sits behind the jux_axi4_if read channels as a synthesizable memory
//  target for the VIP agent's master driver.
// PARAMETERS
//  DATA_WIDTH  2   log2 of data bus bytes; DATA_BYTES=1<<DATA_WIDTH, DATA_BITS=8*DATA_BYTES
//  ADDR_WIDTH  32  AXI byte-address width
//  ID_WIDTH    4   arid/rid width
//  AXI4        1   1: 8-bit arlen; 0: AXI3 4-bit arlen (AXLEN_WIDTH=4+4*AXI4)
//  MEM_AW      10  memory word-address width; decoded range = 2^(MEM_AW+DATA_WIDTH) bytes
// PORTS
//  aclk         in   1            clock, all logic on rising edge
//  areset       in   1            synchronous reset, active-high
//  arid         in   ID_WIDTH     read ID
//  araddr       in   ADDR_WIDTH   start byte address
//  arlen        in   AXLEN_WIDTH  beats-1
//  arsize       in   3            log2 bytes per beat
//  arburst      in   2            00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  arvalid      in   1            AR valid
//  arready      out  1            AR ready
//  rid          out  ID_WIDTH     = latched arid
//  rdata        out  DATA_BITS    full-width word; master selects narrow lanes
//  rresp        out  2            00 OKAY, 10 SLVERR, 11 DECERR
//  rlast        out  1            final beat
//  rvalid       out  1            R valid
//  rready       in   1            R ready
//  mem_rd_en    out  1            memory read strobe
//  mem_rd_addr  out  MEM_AW       word address = cur_addr[MEM_AW+DATA_WIDTH-1:DATA_WIDTH]
//  mem_rd_data  in   DATA_BITS    valid the cycle after mem_rd_en
// BEHAVIOUR
//  Reset: state=IDLE; arready=0, rvalid=0, rlast=0, mem_rd_en=0, rid/rdata/rresp=0.
//  FSM: IDLE -> REQ -> CAP -> RESP -> (REQ | IDLE). arready=1 only in IDLE; arlock/cache/prot ignored.
//  IDLE: on arvalid&arready (cycle T) latch id, addr, len, size, burst, error code; beat_cnt=0.
//  REQ (T+1): mem_rd_en=1 unless burst has error. CAP (T+2): rdata<=mem_rd_data (0 on error).
//  RESP (from T+3): rvalid=1, rlast=(beat_cnt==len); rid/rdata/rresp/rlast stable while !rready.
//  On rvalid&rready: last -> IDLE (arready=1 next cycle); else advance addr, beat_cnt++, -> REQ.
//  First-beat latency 3 cycles from AR handshake; 3 cycles/beat with rready held high.
//  Error classification at AR handshake, applied to every beat of the burst:
//   araddr[ADDR_WIDTH-1:MEM_AW+DATA_WIDTH]!=0 -> DECERR; else arsize>DATA_WIDTH, arburst==11,
//   or WRAP with arlen not in {1,3,7,15} or araddr not size-aligned -> SLVERR; else OKAY.
//   Error bursts still return exactly arlen+1 beats, no memory reads, rdata=0.
//  Address update (sz=1<<size): FIXED: unchanged. INCR: addr=(addr&~(sz-1))+sz (aligns after
//   beat 0), modulo 2^ADDR_WIDTH. WRAP: mask=(len+1)*sz-1; addr=(addr&~mask)|((addr+sz)&mask).
//  INCR crossing top of memory mid-burst: remaining beats DECERR (range checked per beat).
//  4KB-boundary violation not checked (master responsibility). arlen=0 -> single beat, rlast=1.
//  areset mid-burst: next edge returns to reset values; in-flight burst dropped, no rlast.
// STRUCTURE
//  jux_axi4_pkg: axi_burst_e, axi_resp_e, rd_state_e (IDLE/REQ/CAP/RESP) typedefs.
//  Sub-module jux_axi4_addr_gen: combinational next-address (addr,size,len,burst -> next_addr),
//  reused later by the write-side responder.
// TESTING
//  INCR araddr=0x10,arlen=3,arsize=2,arid=5 -> 4 beats words 4..7, rid=5, OKAY, rlast on beat 4.
//  WRAP araddr=0x38,arlen=3,arsize=2 -> word addrs 0xE,0xF,0xC,0xD; rlast on 4th.
//  FIXED arlen=2 at 0x20 -> 3 beats all mem word 8; rready low 5 cycles mid-burst -> R held stable.
//  araddr=0x1000 with MEM_AW=10 -> arlen+1 DECERR beats, mem_rd_en never high; arsize=3 -> SLVERR.
//  INCR araddr=0xFF8,arlen=3,arsize=2 -> beats 1-2 OKAY, beats 3-4 DECERR.
//  areset high during beat 2 of 8 -> rvalid=0,arready=0 next cycle; new AR accepted after release.

Source files
------------

// File: rtl/jux_axi4_pkg.sv
// Shared AXI4 typedefs for the jux_axi4 responder blocks.
//   axi_burst_e : AxBURST encodings
//   axi_resp_e  : xRESP encodings
//   rd_state_e  : read-responder FSM states
package jux_axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_CAP,
    ST_RESP
  } rd_state_e;

endpackage

// File: rtl/jux_axi4_addr_gen.sv
// Combinational AXI burst next-address generator.
//   addr      in  current beat byte address
//   size      in  log2 bytes per beat
//   len       in  beats-1 (zero-extended to 8 bits)
//   burst     in  FIXED / INCR / WRAP (reserved holds address)
//   next_addr out address of the following beat
module jux_axi4_addr_gen #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  import jux_axi4_pkg::*;

  logic [ADDR_WIDTH-1:0] sz;
  logic [ADDR_WIDTH-1:0] mask;

  always_comb begin
    sz        = ADDR_WIDTH'(1) << size;
    mask      = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * sz - ADDR_WIDTH'(1);
    next_addr = addr;
    case (axi_burst_e'(burst))
      // INCR aligns an unaligned start address after the first beat
      BURST_INCR: next_addr = (addr & ~(sz - ADDR_WIDTH'(1))) + sz;
      BURST_WRAP: next_addr = (addr & ~mask) | ((addr + sz) & mask);
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/jux_axi4_rd_slave.sv
// AXI4 read-channel responder (AR/R slave) in front of a 1-cycle-latency
// synchronous word memory. One burst at a time; every beat costs REQ/CAP/RESP.
//   aclk, areset          clock, synchronous active-high reset
//   ar* (in), arready     read address channel
//   r* (out), rready      read data channel
//   mem_rd_en/addr (out)  memory read strobe and word address
//   mem_rd_data (in)      memory data, valid the cycle after mem_rd_en
module jux_axi4_rd_slave #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int AXI4       = 1,
  parameter int MEM_AW     = 10
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [ID_WIDTH-1:0]              arid,
  input  logic [ADDR_WIDTH-1:0]            araddr,
  input  logic [3+4*AXI4:0]                arlen,
  input  logic [2:0]                       arsize,
  input  logic [1:0]                       arburst,
  input  logic                             arvalid,
  output logic                             arready,
  output logic [ID_WIDTH-1:0]              rid,
  output logic [8*(1<<DATA_WIDTH)-1:0]     rdata,
  output logic [1:0]                       rresp,
  output logic                             rlast,
  output logic                             rvalid,
  input  logic                             rready,
  output logic                             mem_rd_en,
  output logic [MEM_AW-1:0]                mem_rd_addr,
  input  logic [8*(1<<DATA_WIDTH)-1:0]     mem_rd_data
);
  import jux_axi4_pkg::*;

  localparam int DATA_BITS = 8 * (1 << DATA_WIDTH);
  localparam int RANGE_LSB = MEM_AW + DATA_WIDTH;

  rd_state_e             state, next_state;
  logic                  arready_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q, next_addr, ar_sz;
  logic [7:0]            len_q, beat_cnt, ar_len8;
  logic [2:0]            size_q;
  axi_burst_e            burst_q;
  axi_resp_e             err_q, ar_err, beat_resp, resp_q;
  logic [DATA_BITS-1:0]  rdata_q;
  logic                  ar_hs, last_beat;

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> RANGE_LSB) != '0;
  endfunction

  jux_axi4_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // Burst-level error classification at AR handshake; DECERR has priority.
  always_comb begin
    ar_len8 = 8'(arlen);
    ar_sz   = ADDR_WIDTH'(1) << arsize;
    ar_err  = RESP_OKAY;
    if (out_of_range(araddr))
      ar_err = RESP_DECERR;
    else if ((int'(arsize) > DATA_WIDTH) || (arburst == BURST_RSVD) ||
             ((arburst == BURST_WRAP) &&
              (!(ar_len8 inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
               ((araddr & (ar_sz - ADDR_WIDTH'(1))) != '0))))
      ar_err = RESP_SLVERR;
  end

  // A latched burst error is sticky; otherwise range is rechecked every beat so
  // an INCR burst running off the top of memory turns DECERR mid-burst.
  always_comb begin
    if (err_q != RESP_OKAY)      beat_resp = err_q;
    else if (out_of_range(addr_q)) beat_resp = RESP_DECERR;
    else                         beat_resp = RESP_OKAY;
  end

  assign ar_hs     = (state == ST_IDLE) && arvalid && arready_q;
  assign rvalid    = (state == ST_RESP);
  assign last_beat = (beat_cnt == len_q);
  assign rlast     = rvalid && last_beat;
  assign arready   = arready_q;
  assign rid       = id_q;
  assign rdata     = rdata_q;
  assign rresp     = resp_q;
  assign mem_rd_addr = addr_q[RANGE_LSB-1:DATA_WIDTH];

  always_comb begin
    next_state = state;
    mem_rd_en  = 1'b0;
    case (state)
      ST_IDLE: if (ar_hs) next_state = ST_REQ;
      ST_REQ: begin
        mem_rd_en  = (beat_resp == RESP_OKAY);
        next_state = ST_CAP;
      end
      ST_CAP:  next_state = ST_RESP;
      ST_RESP: if (rready) next_state = last_beat ? ST_IDLE : ST_REQ;
      default: next_state = ST_IDLE;
    endcase
  end

  // arready is registered from next_state so it is low out of reset and
  // rises the cycle after the last R handshake.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= ST_IDLE;
      arready_q <= 1'b0;
    end else begin
      state     <= next_state;
      arready_q <= (next_state == ST_IDLE);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= BURST_FIXED;
      err_q    <= RESP_OKAY;
      beat_cnt <= '0;
      rdata_q  <= '0;
      resp_q   <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        id_q     <= arid;
        addr_q   <= araddr;
        len_q    <= ar_len8;
        size_q   <= arsize;
        burst_q  <= axi_burst_e'(arburst);
        err_q    <= ar_err;
        beat_cnt <= '0;
      end
      if (state == ST_CAP) begin
        rdata_q <= (beat_resp == RESP_OKAY) ? mem_rd_data : '0;
        resp_q  <= beat_resp;
      end
      if ((state == ST_RESP) && rready && !last_beat) begin
        addr_q   <= next_addr;
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

endmodule
